prod_bcd_conv: RTL



---
 rtl/prod_bcd_conv_if.sv | 40 ++++
 rtl/prod_bcd_conv.sv | 123 ++++++++++++
 2 files changed

// File: rtl/prod_bcd_conv_if.sv
// -----------------------------------------------------------------------------
// prod_bcd_conv_if
// Handshake bundle between the multiplier product stage, the binary-to-BCD
// converter and the display driver.
//
// Signals:
//   in_valid  upstream -> conv   in_data holds a product to convert
//   in_ready  conv -> upstream   converter can accept a new value
//   in_data   upstream -> conv   binary product, WIDTH bits
//   out_valid conv -> consumer   bcd holds a finished result
//   out_ready consumer -> conv   consumer accepts the result
//   bcd       conv -> consumer   packed BCD digits, most significant digit on top
//   busy      conv -> observer   conversion in progress
//
// Modports:
//   slave  : the converter
//   master : the environment (producer + consumer)
// -----------------------------------------------------------------------------
interface prod_bcd_conv_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, bcd, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, bcd, busy
   );
endinterface

// File: rtl/prod_bcd_conv.sv
// -----------------------------------------------------------------------------
// prod_bcd_conv
// Sequential binary-to-BCD converter for the multiplier product. Uses the
// shift-add-3 (double-dabble) algorithm, one input bit per clock.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    prod_bcd_conv_if.slave: valid/ready on the input (in_*) and
//          output (out_*) sides, packed BCD result and busy flag
//
// Timing: a value accepted at edge k is presented with out_valid after edge
// k+WIDTH; the result stays up until out_ready is seen. bcd holds its last
// result while idle and only changes when a new conversion completes.
// -----------------------------------------------------------------------------
module prod_bcd_conv #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   prod_bcd_conv_if.slave       bus
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WIDTH-1:0]    r_shift;
   logic [BW-1:0]       r_scratch;
   logic [BW-1:0]       r_bcd;
   logic [CW-1:0]       r_cnt;

   logic [BW-1:0]       w_adj;
   logic [BW+WIDTH-1:0] w_shifted;
   logic                w_last;

   // Correction step: any digit of 5 or more would reach 10+ after doubling,
   // so add 3 first to make the doubled value carry into the next digit.
   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   // One shift of the combined {digits, binary} register: the binary MSB
   // moves into the LSB of the ones digit.
   assign w_shifted = {w_adj, r_shift} << 1;
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            bus.busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: the datapath registers are reset too, so an aborted conversion
   // leaves no stale digits behind and bcd reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_shift   <= bus.in_data;
                  r_scratch <= '0;
                  r_cnt     <= '0;
               end
            end
            S_SHIFT: begin
               r_scratch <= w_shifted[BW+WIDTH-1:WIDTH];
               r_shift   <= w_shifted[WIDTH-1:0];
               r_cnt     <= r_cnt + CW'(1);
               if (w_last) r_bcd <= w_shifted[BW+WIDTH-1:WIDTH];
            end
            default: ;
         endcase
      end
   end

   assign bus.bcd = r_bcd;

endmodule
